// File: rtl/cache_axi_arbiter_pkg.sv
// rtl/cache_axi_arbiter_pkg.sv - request/AXI encodings and FSM states shared by the arbiter
package cache_axi_pkg;

  localparam logic [2:0] RD_TYPE_WORD      = 3'b010;
  localparam logic [2:0] RD_TYPE_CACHELINE = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [3:0] AXI_ID_ICACHE     = 4'd0;
  localparam logic [3:0] AXI_ID_DCACHE     = 4'd1;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wr_state_t;
  typedef enum logic {OWN_ICACHE, OWN_DCACHE} owner_t;

  // Line bursts start at the line base; word accesses keep their byte address.
  function automatic logic [31:0] burst_addr(input logic [31:0] addr, input logic is_line,
                                             input int unsigned offset_bits);
    logic [31:0] mask;
    mask = ~((32'd1 << offset_bits) - 32'd1);
    return is_line ? (addr & mask) : addr;
  endfunction

  function automatic logic [7:0] burst_len(input logic is_line, input int unsigned words);
    return is_line ? 8'(words - 1) : 8'd0;
  endfunction

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// rtl/cache_axi_arbiter_if.sv - AXI4 master port bundle shared by the arbiter and the SoC bus
interface cache_axi_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/cache_axi_arbiter_wr_buffer.sv
// rtl/cache_axi_arbiter_wr_buffer.sv - single-entry dcache write buffer driving the AXI write channels
module axi_wr_buffer
  import cache_axi_pkg::*;
#(
  parameter int LINE_WORDS  = 8,
  parameter int LINE_WIDTH  = 32 * LINE_WORDS,
  parameter int LINE_OFFSET = $clog2(LINE_WORDS * 4)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [LINE_WIDTH-1:0]   wr_data,
  output logic                    wr_rdy,
  output logic                    busy,
  output logic [31-LINE_OFFSET:0] busy_line,
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready
);
  localparam int BEAT_W = $clog2(LINE_WORDS);

  wr_state_t             state, state_nx;
  logic [BEAT_W-1:0]     beat;
  logic [31:0]           addr_q;
  logic                  line_q;
  logic [3:0]            wstrb_q;
  logic [LINE_WIDTH-1:0] data_q;

  assign wr_rdy    = ~reset & (state == W_IDLE);
  assign busy      = (state != W_IDLE);
  assign busy_line = addr_q[31:LINE_OFFSET];

  always_ff @(posedge clk) begin
    if (reset) begin
        state <= W_IDLE;
        beat  <= '0;
    end else begin
        state <= state_nx;
        if (state == W_AW)
            beat <= '0;
        else if (wvalid && wready)
            beat <= beat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_req && wr_rdy) begin
        addr_q  <= wr_addr;
        line_q  <= (wr_type == RD_TYPE_CACHELINE);
        wstrb_q <= wr_wstrb;
        data_q  <= wr_data;
    end
  end

  always_comb begin
    state_nx = state;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    case (state)
      W_IDLE: if (wr_req && wr_rdy) state_nx = W_AW;
      W_AW: begin
          awvalid = 1'b1;
          if (awready) state_nx = W_DATA;
      end
      W_DATA: begin
          wvalid = 1'b1;
          if (wready && wlast) state_nx = W_B;
      end
      W_B: begin
          bready = 1'b1;
          if (bvalid) state_nx = W_IDLE;
      end
      default: state_nx = W_IDLE;
    endcase
  end

  assign awid    = AXI_ID_DCACHE;
  assign awaddr  = burst_addr(addr_q, line_q, LINE_OFFSET);
  assign awlen   = burst_len(line_q, LINE_WORDS);
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign wdata   = data_q[32*beat +: 32];
  assign wstrb   = line_q ? 4'hF : wstrb_q;
  assign wlast   = line_q ? (beat == BEAT_W'(LINE_WORDS - 1)) : 1'b1;

endmodule

// File: rtl/cache_axi_arbiter.sv
// rtl/cache_axi_arbiter.sv - round-robin icache/dcache read arbiter plus dcache write buffer on one AXI4 port
module cache_axi_arbiter
  import cache_axi_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int LINE_WIDTH = 32 * LINE_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rd_req,
  input  logic [2:0]            i_rd_type,
  input  logic [31:0]           i_rd_addr,
  output logic                  i_rd_rdy,
  output logic                  i_ret_valid,
  output logic                  i_ret_last,
  output logic [31:0]           i_ret_data,
  input  logic                  d_rd_req,
  input  logic [2:0]            d_rd_type,
  input  logic [31:0]           d_rd_addr,
  output logic                  d_rd_rdy,
  output logic                  d_ret_valid,
  output logic                  d_ret_last,
  output logic [31:0]           d_ret_data,
  input  logic                  d_wr_req,
  input  logic [2:0]            d_wr_type,
  input  logic [31:0]           d_wr_addr,
  input  logic [3:0]            d_wr_wstrb,
  input  logic [LINE_WIDTH-1:0] d_wr_data,
  output logic                  d_wr_rdy,
  cache_axi_arbiter_if.master   axi
);
  localparam int LINE_OFFSET = $clog2(LINE_WORDS * 4);

  rd_state_t                rd_state, rd_state_nx;
  owner_t                   last_owner, owner_q;
  logic [31:0]              rd_addr_q;
  logic                     rd_line_q;
  logic                     grant_i, grant_d, haz_i, haz_d, wr_accept;
  logic                     accept_i, accept_d;
  logic                     ar_valid, r_ready;
  logic                     wb_busy;
  logic [31-LINE_OFFSET:0]  wb_line;
  logic                     unused_axi;

  assign unused_axi = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

  // A tie goes to whoever was not served last.
  assign grant_i = i_rd_req & (~d_rd_req | (last_owner == OWN_DCACHE));
  assign grant_d = d_rd_req & (~i_rd_req | (last_owner == OWN_ICACHE));

  // Reads must not overtake a buffered or just-accepted write to the same line.
  assign wr_accept = d_wr_req & d_wr_rdy;
  assign haz_i = (wb_busy && (wb_line == i_rd_addr[31:LINE_OFFSET])) ||
                 (wr_accept && (d_wr_addr[31:LINE_OFFSET] == i_rd_addr[31:LINE_OFFSET]));
  assign haz_d = (wb_busy && (wb_line == d_rd_addr[31:LINE_OFFSET])) ||
                 (wr_accept && (d_wr_addr[31:LINE_OFFSET] == d_rd_addr[31:LINE_OFFSET]));

  assign i_rd_rdy = ~reset & (rd_state == R_IDLE) & grant_i & ~haz_i;
  assign d_rd_rdy = ~reset & (rd_state == R_IDLE) & grant_d & ~haz_d;
  assign accept_i = i_rd_req & i_rd_rdy;
  assign accept_d = d_rd_req & d_rd_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
        rd_state   <= R_IDLE;
        last_owner <= OWN_ICACHE;
        owner_q    <= OWN_ICACHE;
    end else begin
        rd_state <= rd_state_nx;
        if (accept_i) begin
            last_owner <= OWN_ICACHE;
            owner_q    <= OWN_ICACHE;
        end else if (accept_d) begin
            last_owner <= OWN_DCACHE;
            owner_q    <= OWN_DCACHE;
        end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_i) begin
        rd_addr_q <= i_rd_addr;
        rd_line_q <= (i_rd_type == RD_TYPE_CACHELINE);
    end else if (accept_d) begin
        rd_addr_q <= d_rd_addr;
        rd_line_q <= (d_rd_type == RD_TYPE_CACHELINE);
    end
  end

  always_comb begin
    rd_state_nx = rd_state;
    ar_valid    = 1'b0;
    r_ready     = 1'b0;
    case (rd_state)
      R_IDLE: if (accept_i || accept_d) rd_state_nx = R_AR;
      R_AR: begin
          ar_valid = 1'b1;
          if (axi.arready) rd_state_nx = R_DATA;
      end
      R_DATA: begin
          r_ready = 1'b1;
          if (axi.rvalid && axi.rlast) rd_state_nx = R_IDLE;
      end
      default: rd_state_nx = R_IDLE;
    endcase
  end

  assign axi.arvalid = ar_valid;
  assign axi.rready  = r_ready;
  assign axi.arid    = (owner_q == OWN_DCACHE) ? AXI_ID_DCACHE : AXI_ID_ICACHE;
  assign axi.araddr  = burst_addr(rd_addr_q, rd_line_q, LINE_OFFSET);
  assign axi.arlen   = burst_len(rd_line_q, LINE_WORDS);
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = AXI_BURST_INCR;

  // Return routing follows the owner register, never rid.
  assign i_ret_valid = r_ready & (owner_q == OWN_ICACHE) & axi.rvalid;
  assign d_ret_valid = r_ready & (owner_q == OWN_DCACHE) & axi.rvalid;
  assign i_ret_last  = i_ret_valid & axi.rlast;
  assign d_ret_last  = d_ret_valid & axi.rlast;
  assign i_ret_data  = axi.rdata;
  assign d_ret_data  = axi.rdata;

  axi_wr_buffer #(
    .LINE_WORDS  (LINE_WORDS),
    .LINE_WIDTH  (LINE_WIDTH),
    .LINE_OFFSET (LINE_OFFSET)
  ) u_wr_buffer (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (d_wr_req),
    .wr_type   (d_wr_type),
    .wr_addr   (d_wr_addr),
    .wr_wstrb  (d_wr_wstrb),
    .wr_data   (d_wr_data),
    .wr_rdy    (d_wr_rdy),
    .busy      (wb_busy),
    .busy_line (wb_line),
    .awid      (axi.awid),
    .awaddr    (axi.awaddr),
    .awlen     (axi.awlen),
    .awsize    (axi.awsize),
    .awburst   (axi.awburst),
    .awvalid   (axi.awvalid),
    .awready   (axi.awready),
    .wdata     (axi.wdata),
    .wstrb     (axi.wstrb),
    .wlast     (axi.wlast),
    .wvalid    (axi.wvalid),
    .wready    (axi.wready),
    .bvalid    (axi.bvalid),
    .bready    (axi.bready)
  );

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb/tb_cache_axi_arbiter.sv - directed vector bench for cache_axi_arbiter
module tb_cache_axi_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic         i_rd_req, d_rd_req, d_wr_req;
  logic [2:0]   i_rd_type, d_rd_type, d_wr_type;
  logic [31:0]  i_rd_addr, d_rd_addr, d_wr_addr;
  logic [3:0]   d_wr_wstrb;
  logic [255:0] d_wr_data;
  logic         i_rd_rdy, d_rd_rdy, d_wr_rdy;
  logic         i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
  logic [31:0]  i_ret_data, d_ret_data;
  int           checks = 0;
  int           errors = 0;

  cache_axi_arbiter_if axi();

  cache_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
    .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        i_req;
    logic        d_req;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        exp_i_rdy;
    logic        exp_d_rdy;
    logic        exp_wr_rdy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
    i_rd_type = 3'b010; d_rd_type = 3'b010; d_wr_type = 3'b100;
    i_rd_addr = 0; d_rd_addr = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rdata = 0; axi.rid = 0; axi.rresp = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;
    tick();
    tick();
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_rready", axi.rready, 0);
    check("rst_bready", axi.bready, 0);
    check("rst_ret_valid", {i_ret_valid, d_ret_valid}, 0);
    check("rst_rd_rdy", {i_rd_rdy, d_rd_rdy}, 0);
    check("rst_wr_rdy", d_wr_rdy, 0);
    reset = 1'b0;
  endtask

  // Completes a read sitting in R_AR; beat k carries base+k.
  task automatic finish_read(input int beats, input logic is_i, input logic [31:0] base);
    check("fr_arvalid", axi.arvalid, 1);
    axi.arready = 1;
    tick();
    axi.arready = 0;
    for (int k = 0; k < beats; k++) begin
        axi.rvalid = 1;
        axi.rdata  = base + k;
        axi.rlast  = (k == beats - 1);
        #1;
        check("fr_ret_valid", is_i ? {i_ret_valid, d_ret_valid} : {d_ret_valid, i_ret_valid}, 2'b10);
        check("fr_ret_data", is_i ? i_ret_data : d_ret_data, base + k);
        check("fr_ret_last", is_i ? i_ret_last : d_ret_last, (k == beats - 1));
        tick();
    end
    axi.rvalid = 0;
    axi.rlast  = 0;
    check("fr_rready_idle", axi.rready, 0);
  endtask

  initial begin
    logic [255:0] line;
    int           beat;

    vecs[0] = '{"none",        0, 0, 32'h0,    32'h0,    0, 32'h0,    0, 0, 1};
    vecs[1] = '{"i_only",      1, 0, 32'h100,  32'h0,    0, 32'h0,    1, 0, 1};
    vecs[2] = '{"d_only",      0, 1, 32'h0,    32'h200,  0, 32'h0,    0, 1, 1};
    vecs[3] = '{"tie",         1, 1, 32'h100,  32'h200,  0, 32'h0,    0, 1, 1};
    vecs[4] = '{"i_haz_same",  1, 0, 32'h1010, 32'h0,    1, 32'h1000, 0, 0, 1};
    vecs[5] = '{"i_other_ln",  1, 0, 32'h1020, 32'h0,    1, 32'h1000, 1, 0, 1};
    vecs[6] = '{"d_haz_same",  0, 1, 32'h0,    32'h40,   1, 32'h5C,   0, 0, 1};
    vecs[7] = '{"tie_d_haz",   1, 1, 32'h100,  32'h200,  1, 32'h200,  0, 0, 1};
    for (int k = 0; k < 8; k++) line[32*k +: 32] = 32'hA000_0000 + k;

    do_reset();

    for (int v = 0; v < 8; v++) begin
        i_rd_req = vecs[v].i_req; d_rd_req = vecs[v].d_req;
        i_rd_addr = vecs[v].i_addr; d_rd_addr = vecs[v].d_addr;
        d_wr_req = vecs[v].wr_req; d_wr_addr = vecs[v].wr_addr;
        #1;
        check({"vec_i_rdy_", vecs[v].name}, i_rd_rdy, vecs[v].exp_i_rdy);
        check({"vec_d_rdy_", vecs[v].name}, d_rd_rdy, vecs[v].exp_d_rdy);
        check({"vec_wr_rdy_", vecs[v].name}, d_wr_rdy, vecs[v].exp_wr_rdy);
        i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
        tick();
    end

    // Line read
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0040;
    #1 check("line_i_rdy", i_rd_rdy, 1);
    tick();
    i_rd_req = 0;
    check("line_araddr", axi.araddr, 32'h1C00_0040);
    check("line_arlen", axi.arlen, 7);
    check("line_arid", axi.arid, 0);
    check("line_arsize_burst", {axi.arsize, axi.arburst}, {3'b010, 2'b01});
    finish_read(8, 1, 32'h0);

    // Tie after reset: dcache first, icache right after rlast
    do_reset();
    i_rd_req = 1; i_rd_type = 3'b010; i_rd_addr = 32'h100;
    d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h200;
    #1;
    check("tie_d_rdy", d_rd_rdy, 1);
    check("tie_i_rdy", i_rd_rdy, 0);
    tick();
    d_rd_req = 0;
    check("tie_arid_d", axi.arid, 1);
    check("tie_araddr_d", axi.araddr, 32'h200);
    check("tie_i_blocked", i_rd_rdy, 0);
    finish_read(1, 0, 32'h55);
    check("tie_i_next", i_rd_rdy, 1);
    tick();
    i_rd_req = 0;
    check("tie_arid_i", axi.arid, 0);
    check("tie_araddr_i", axi.araddr, 32'h100);
    finish_read(1, 1, 32'h66);

    // Uncached word read
    d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'hBFAF_8004;
    #1 check("word_d_rdy", d_rd_rdy, 1);
    tick();
    d_rd_req = 0;
    check("word_arlen", axi.arlen, 0);
    check("word_araddr", axi.araddr, 32'hBFAF_8004);
    finish_read(1, 0, 32'hDEAD_BEEF);

    // Read hazard against buffered line write
    d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h1000; d_wr_data = line;
    #1 check("haz_wr_rdy", d_wr_rdy, 1);
    tick();
    d_wr_req = 0;
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1010;
    #1;
    check("haz_i_blocked_aw", i_rd_rdy, 0);
    check("haz_awvalid", axi.awvalid, 1);
    check("haz_awaddr", axi.awaddr, 32'h1000);
    check("haz_awlen_id", {axi.awlen, axi.awid}, {8'd7, 4'd1});
    axi.awready = 1;
    tick();
    axi.awready = 0;
    axi.wready = 1;
    for (int k = 0; k < 8; k++) begin
        check("haz_i_blocked_w", i_rd_rdy, 0);
        tick();
    end
    axi.wready = 0;
    check("haz_bready", axi.bready, 1);
    check("haz_i_blocked_b", i_rd_rdy, 0);
    axi.bvalid = 1;
    tick();
    axi.bvalid = 0;
    check("haz_i_release", i_rd_rdy, 1);
    check("haz_wr_free", d_wr_rdy, 1);
    tick();
    i_rd_req = 0;
    check("haz_araddr", axi.araddr, 32'h1000);
    finish_read(8, 1, 32'h100);

    // Line write with wready stalls
    d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h2000; d_wr_data = line;
    tick();
    d_wr_req = 0;
    check("ws_awvalid", axi.awvalid, 1);
    tick();
    check("ws_awvalid_hold", axi.awvalid, 1);
    check("ws_awaddr_hold", axi.awaddr, 32'h2000);
    axi.awready = 1;
    tick();
    axi.awready = 0;
    beat = 0;
    for (int c = 0; c < 40 && beat < 8; c++) begin
        axi.wready = c[0];
        #1;
        check("ws_wvalid", axi.wvalid, 1);
        check("ws_wdata", axi.wdata, 32'hA000_0000 + beat);
        if (axi.wready) begin
            check("ws_wstrb", axi.wstrb, 4'hF);
            check("ws_wlast", axi.wlast, (beat == 7));
            beat++;
        end
        tick();
    end
    axi.wready = 0;
    check("ws_beats", beat, 8);
    check("ws_bready", axi.bready, 1);
    check("ws_wr_busy", d_wr_rdy, 0);
    axi.bvalid = 1;
    tick();
    axi.bvalid = 0;
    check("ws_wr_free", d_wr_rdy, 1);

    // Uncached word store
    d_wr_req = 1; d_wr_type = 3'b010; d_wr_addr = 32'h3004; d_wr_wstrb = 4'h6;
    d_wr_data = {224'b0, 32'h1234_5678};
    tick();
    d_wr_req = 0;
    check("ww_awaddr", axi.awaddr, 32'h3004);
    check("ww_awlen", axi.awlen, 0);
    axi.awready = 1;
    tick();
    axi.awready = 0;
    axi.wready = 1;
    #1;
    check("ww_wdata", axi.wdata, 32'h1234_5678);
    check("ww_wstrb_wlast", {axi.wstrb, axi.wlast}, {4'h6, 1'b1});
    tick();
    axi.wready = 0;
    check("ww_bready", axi.bready, 1);
    axi.bvalid = 1;
    tick();
    axi.bvalid = 0;

    // Reset during R_DATA beat 3
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0080;
    tick();
    i_rd_req = 0;
    axi.arready = 1;
    tick();
    axi.arready = 0;
    for (int k = 0; k < 3; k++) begin
        axi.rvalid = 1; axi.rdata = k; axi.rlast = 0;
        tick();
    end
    reset = 1;
    tick();
    reset = 0;
    axi.rvalid = 0;
    #1;
    check("mid_rst_rready", axi.rready, 0);
    check("mid_rst_arvalid", axi.arvalid, 0);
    check("mid_rst_ret", i_ret_valid, 0);
    d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h40;
    #1 check("mid_rst_d_rdy", d_rd_rdy, 1);
    tick();
    d_rd_req = 0;
    check("mid_rst_araddr", axi.araddr, 32'h40);
    finish_read(1, 0, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
